// File: rtl/m72_ioctl_pkg.sv
// ---------------------------------------------------------------------------
// m72_ioctl_pkg
// Shared definitions for the m72 host ioctl path (ROM download decoder and
// NVRAM upload reader).
//   ADDR_W      : width of the host ioctl byte address.
//   IDX_ROM     : ioctl_index used for the ROM download image.
//   IDX_NVRAM   : ioctl_index used for the NVRAM / hiscore upload image.
//   upl_state_t : state encoding of the upload reader FSM.
// ---------------------------------------------------------------------------
package m72_ioctl_pkg;

   localparam int ADDR_W = 25;

   localparam logic [7:0] IDX_ROM   = 8'h00;
   localparam logic [7:0] IDX_NVRAM = 8'h04;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } upl_state_t;

endpackage

// File: rtl/ioctl_word_cache.sv
// ---------------------------------------------------------------------------
// ioctl_word_cache
// One-entry cache of the last 16-bit memory word read for the host, so the
// second byte of a word is served without another memory access.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : capture load_data under load_tag and mark valid
//   invalidate     : drop the entry (wins over load)
//   load_tag       : word address of the data being loaded
//   load_data      : 16-bit word being loaded
//   lookup_tag     : word address being looked up
//   hit            : entry valid and its tag equals lookup_tag
//   data           : cached word
// ---------------------------------------------------------------------------
module ioctl_word_cache #(
   parameter int AW = 12
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          load,
   input  logic          invalidate,
   input  logic [AW-1:0] load_tag,
   input  logic [15:0]   load_data,
   input  logic [AW-1:0] lookup_tag,
   output logic          hit,
   output logic [15:0]   data
);

   logic          valid;
   logic [AW-1:0] tag;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (invalidate) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         tag   <= load_tag;
         data  <= load_data;
      end
   end

   assign hit = valid & (tag == lookup_tag);

endmodule

// File: rtl/ioctl_upload_reader.sv
// ---------------------------------------------------------------------------
// ioctl_upload_reader
// Core-side responder for the host ioctl upload (read-back) path. While the
// host has an upload session open on INDEX, every rising edge of ioctl_rd is
// answered with one byte of a 16-bit memory (little-endian byte order).
//
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   ioctl_upload        : host upload session active (level)
//   ioctl_index         : host image index
//   ioctl_rd            : host read strobe, acted on at its rising edge
//   ioctl_addr          : host byte address, stable between read strobes
//   ioctl_din           : byte returned to the host
//   ioctl_wait          : host stall; no new ioctl_rd while high
//   mem_req / mem_addr  : memory read request and word address
//   mem_ack / mem_data  : one-cycle acknowledge with the read word
//   upload_active       : registered session-active flag
//   upload_done         : one-cycle pulse when the session ends
//   timeout_err         : sticky, set when a fetch timed out
//   bytes_read          : served reads this session, saturating
//   fsm_state           : current FSM state, for observation
//
// Memory handshake: mem_req rises with mem_addr valid and both are held
// unchanged until the cycle in which mem_ack is high; mem_data is taken in
// that same cycle and mem_req drops on that edge. A request, once issued,
// is always carried to its ack (a timeout or session end only stops the
// host from waiting on it). Only reset drops a request early.
// ---------------------------------------------------------------------------
module ioctl_upload_reader
   import m72_ioctl_pkg::*;
#(
   parameter logic [7:0]  INDEX   = IDX_NVRAM,
   parameter int          AW      = 12,
   parameter logic [15:0] SIZE    = 16'h1000,
   parameter logic [7:0]  FILL    = 8'hFF,
   parameter int          TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              mem_req,
   output logic [AW-1:0]     mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_data,
   output logic              upload_active,
   output logic              upload_done,
   output logic              timeout_err,
   output logic [15:0]       bytes_read,
   output logic [1:0]        fsm_state
);

   localparam int TW = $clog2(TIMEOUT + 1);

   upl_state_t    state;
   logic          rd_q;
   logic          sess_q;
   logic          sel_q;
   logic          rd_pend;
   logic [TW-1:0] tmo_cnt;

   logic          sess;
   logic          sess_rise;
   logic          sess_fall;
   logic          rd_rise;
   logic          go;
   logic          out_of_range;
   logic [AW-1:0] word;
   logic          cache_hit;
   logic          hit_eff;
   logic [15:0]   cache_data;
   logic          cache_load;
   logic          cache_inval;
   logic [15:0]   br_base;
   logic [15:0]   br_inc;

   assign sess         = ioctl_upload & (ioctl_index == INDEX);
   assign sess_rise    = sess & ~sess_q;
   assign sess_fall    = ~sess & sess_q;
   assign rd_rise      = ioctl_rd & ~rd_q;
   assign word         = ioctl_addr[AW:1];
   assign out_of_range = (ioctl_addr >= ADDR_W'(SIZE));

   // A read deferred during DRAIN is serviced as if it had just arrived.
   assign go = (state == IDLE) & sess & (rd_rise | rd_pend);

   // A session start invalidates the cache on this same edge, so a read
   // arriving together with the start must not use the old entry.
   assign hit_eff = cache_hit & ~sess_rise;

   // Data acked after the session has ended belongs to a dead session.
   assign cache_load  = (state == FETCH) & mem_ack & ~sess_fall;
   assign cache_inval = sess_rise | sess_fall;

   // Count base is zero on the session-start edge so a read served on that
   // same edge counts as the first byte of the new session.
   assign br_base = sess_rise ? 16'd0 : bytes_read;
   assign br_inc  = (br_base == 16'hFFFF) ? br_base : br_base + 16'd1;

   assign fsm_state = state;

   ioctl_word_cache #(
      .AW(AW)
   ) u_cache (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (cache_load),
      .invalidate (cache_inval),
      .load_tag   (mem_addr),
      .load_data  (mem_data),
      .lookup_tag (word),
      .hit        (cache_hit),
      .data       (cache_data)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         rd_q          <= 1'b0;
         sess_q        <= 1'b0;
         sel_q         <= 1'b0;
         rd_pend       <= 1'b0;
         tmo_cnt       <= '0;
         ioctl_din     <= 8'h00;
         ioctl_wait    <= 1'b0;
         mem_req       <= 1'b0;
         mem_addr      <= '0;
         upload_active <= 1'b0;
         upload_done   <= 1'b0;
         timeout_err   <= 1'b0;
         bytes_read    <= 16'h0000;
      end else begin
         rd_q          <= ioctl_rd;
         sess_q        <= sess;
         upload_active <= sess;
         upload_done   <= sess_fall;
         bytes_read    <= br_base;
         if (sess_rise) begin
            timeout_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               rd_pend    <= 1'b0;
               ioctl_wait <= 1'b0;
               if (go) begin
                  if (out_of_range) begin
                     ioctl_din  <= FILL;
                     bytes_read <= br_inc;
                  end else if (hit_eff) begin
                     ioctl_din  <= ioctl_addr[0] ? cache_data[15:8] : cache_data[7:0];
                     bytes_read <= br_inc;
                  end else begin
                     ioctl_wait <= 1'b1;
                     mem_req    <= 1'b1;
                     mem_addr   <= word;
                     sel_q      <= ioctl_addr[0];
                     tmo_cnt    <= TW'(TIMEOUT);
                     state      <= FETCH;
                  end
               end
            end

            FETCH: begin
               // rd_rise here is a host protocol violation and is ignored.
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  ioctl_wait <= 1'b0;
                  state      <= IDLE;
                  if (!sess_fall) begin
                     ioctl_din  <= sel_q ? mem_data[15:8] : mem_data[7:0];
                     bytes_read <= br_inc;
                  end
               end else if (sess_fall) begin
                  ioctl_wait <= 1'b0;
                  state      <= DRAIN;
               end else if (tmo_cnt == '0) begin
                  ioctl_din   <= FILL;
                  timeout_err <= 1'b1;
                  bytes_read  <= br_inc;
                  ioctl_wait  <= 1'b0;
                  state       <= DRAIN;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end

            DRAIN: begin
               // A read arriving here is latched and the host is stalled
               // until it has actually been served after the drain.
               if (rd_rise && sess) begin
                  rd_pend    <= 1'b1;
                  ioctl_wait <= 1'b1;
               end
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
               if (sess_fall) begin
                  rd_pend    <= 1'b0;
                  ioctl_wait <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// ---------------------------------------------------------------------------
// tb_ioctl_upload_reader
// Directed bench for ioctl_upload_reader: a host driver task, a behavioural
// memory with programmable ack latency and hold-off, and a scoreboard queue
// of expected host bytes popped when each read completes.
// ---------------------------------------------------------------------------
module tb_ioctl_upload_reader;

   localparam int WAIT_BOUND = 1000;

   logic        clock;
   logic        reset_n;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        upload_active;
   logic        upload_done;
   logic        timeout_err;
   logic [15:0] bytes_read;
   logic [1:0]  fsm_state;

   int          vectors;
   int          miscompares;
   int          hold_cycles;
   int          ack_lat;
   int          req_rises;
   logic [7:0]  last_exp;
   logic [7:0]  exp_q[$];

   ioctl_upload_reader dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .ioctl_upload  (ioctl_upload),
      .ioctl_index   (ioctl_index),
      .ioctl_rd      (ioctl_rd),
      .ioctl_addr    (ioctl_addr),
      .ioctl_din     (ioctl_din),
      .ioctl_wait    (ioctl_wait),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .upload_active (upload_active),
      .upload_done   (upload_done),
      .timeout_err   (timeout_err),
      .bytes_read    (bytes_read),
      .fsm_state     (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
      $fatal(1, "watchdog expired");
   end

   // ---------------- memory contents model ----------------
   function automatic logic [15:0] mem_word(input logic [11:0] w);
      if (w == 12'd0) return 16'hBEEF;
      return {w[7:0] ^ 8'hA5, w[7:0] ^ 8'h3C};
   endfunction

   // ---------------- memory responder ----------------
   // Acks ack_lat+1 clocks after it first sees mem_req, after any hold-off.
   initial begin
      int lat;
      lat      = 0;
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
      forever begin
         @(posedge clock);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            lat     = 0;
         end else if (!mem_req) begin
            lat = 0;
         end else if (hold_cycles > 0) begin
            hold_cycles--;
         end else begin
            lat++;
            if (lat > ack_lat) begin
               mem_ack  = 1'b1;
               mem_data = mem_word(mem_addr);
            end
         end
      end
   end

   // ---------------- request counter ----------------
   initial begin
      logic req_prev;
      req_prev  = 1'b0;
      req_rises = 0;
      forever begin
         @(posedge clock);
         #1;
         if (mem_req && !req_prev) req_rises++;
         req_prev = mem_req;
      end
   end

   // ---------------- check / driver tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One host read: push expectation, raise ioctl_rd, count stalled clocks,
   // then pop and compare the returned byte.
   task automatic host_read(input logic [24:0] a, input logic [7:0] exp,
                            input string tag, output int wait_cycles);
      logic [7:0] e;
      exp_q.push_back(exp);
      last_exp   = exp;
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      tick();
      wait_cycles = 0;
      while (ioctl_wait && wait_cycles < WAIT_BOUND) begin
         wait_cycles++;
         tick();
      end
      ioctl_rd = 1'b0;
      check({tag, "_wait_low"}, 32'(ioctl_wait), 32'd0);
      e = exp_q.pop_front();
      check({tag, "_din"}, 32'(ioctl_din), 32'(e));
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wc;
      int r0;
      int n;
      vectors      = 0;
      miscompares  = 0;
      hold_cycles  = 0;
      ack_lat      = 3;
      reset_n      = 1'b1;
      ioctl_upload = 1'b0;
      ioctl_index  = 8'h04;
      ioctl_rd     = 1'b0;
      ioctl_addr   = '0;
      #1 reset_n = 1'b0;
      repeat (3) tick();

      // reset state
      check("rst_din",    32'(ioctl_din),     32'h0);
      check("rst_wait",   32'(ioctl_wait),    32'h0);
      check("rst_req",    32'(mem_req),       32'h0);
      check("rst_active", 32'(upload_active), 32'h0);
      check("rst_done",   32'(upload_done),   32'h0);
      check("rst_err",    32'(timeout_err),   32'h0);
      check("rst_bytes",  32'(bytes_read),    32'h0);
      check("rst_state",  32'(fsm_state),     32'h0);
      reset_n = 1'b1;
      tick();

      ioctl_upload = 1'b1;
      repeat (2) tick();
      check("sess_active", 32'(upload_active), 32'h1);

      // miss then hit on the same word
      r0 = req_rises;
      host_read(25'h0, 8'hEF, "rd0", wc);
      check("rd0_wait_clocks", 32'(wc), 32'd4);
      host_read(25'h1, 8'hBE, "rd1", wc);
      check("rd1_wait_clocks", 32'(wc), 32'd0);
      check("rd01_req_count", 32'(req_rises - r0), 32'd1);
      check("rd01_bytes", 32'(bytes_read), 32'd2);

      // out of range at SIZE, last in-range byte, huge address
      r0 = req_rises;
      host_read(25'h1000, 8'hFF, "size", wc);
      check("size_wait_clocks", 32'(wc), 32'd0);
      check("size_no_req", 32'(req_rises - r0), 32'd0);
      host_read(25'h0FFF, mem_word(12'h7FF) >> 8, "last", wc);
      check("last_wait_clocks", 32'(wc), 32'd4);
      host_read(25'h1FFFFFF, 8'hFF, "huge", wc);
      check("huge_req_count", 32'(req_rises - r0), 32'd1);
      check("bytes5", 32'(bytes_read), 32'd5);

      // wrong index: no response
      ioctl_index = 8'h03;
      tick();
      check("idx3_done", 32'(upload_done), 32'h1);
      check("idx3_active", 32'(upload_active), 32'h0);
      r0 = req_rises;
      ioctl_addr = 25'h2;
      ioctl_rd   = 1'b1;
      repeat (4) tick();
      check("idx3_din", 32'(ioctl_din), 32'(last_exp));
      check("idx3_req", 32'(mem_req), 32'h0);
      check("idx3_req_count", 32'(req_rises - r0), 32'd0);
      check("idx3_wait", 32'(ioctl_wait), 32'h0);
      check("idx3_bytes_kept", 32'(bytes_read), 32'd5);
      ioctl_rd = 1'b0;
      ioctl_index = 8'h04;
      repeat (2) tick();
      check("sess2_bytes_clr", 32'(bytes_read), 32'd0);
      check("sess2_active", 32'(upload_active), 32'h1);

      // timeout, then a read deferred while draining
      r0 = req_rises;
      hold_cycles = 300;
      host_read(25'h2, 8'hFF, "tmo", wc);
      check("tmo_wait_clocks", 32'(wc), 32'd256);
      check("tmo_err", 32'(timeout_err), 32'h1);
      check("tmo_req_held", 32'(mem_req), 32'h1);
      check("tmo_state_drain", 32'(fsm_state), 32'h2);
      host_read(25'h3, mem_word(12'h1) >> 8, "defer", wc);
      check("defer_req_count", 32'(req_rises - r0), 32'd2);
      check("defer_err_sticky", 32'(timeout_err), 32'h1);
      check("defer_bytes", 32'(bytes_read), 32'd2);

      // session end during a fetch
      host_read(25'h4, mem_word(12'h2), "w2", wc);
      hold_cycles = 20;
      ioctl_addr = 25'h6;
      ioctl_rd   = 1'b1;
      tick();
      check("abort_wait_hi", 32'(ioctl_wait), 32'h1);
      ioctl_upload = 1'b0;
      tick();
      check("abort_wait_lo", 32'(ioctl_wait), 32'h0);
      check("abort_done", 32'(upload_done), 32'h1);
      check("abort_din", 32'(ioctl_din), 32'(mem_word(12'h2) & 16'h00FF));
      check("abort_drain", 32'(fsm_state), 32'h2);
      check("abort_req_held", 32'(mem_req), 32'h1);
      tick();
      check("abort_done_pulse", 32'(upload_done), 32'h0);
      n = 0;
      while (mem_req && n < WAIT_BOUND) begin
         n++;
         tick();
      end
      check("abort_req_drained", 32'(mem_req), 32'h0);
      check("abort_idle", 32'(fsm_state), 32'h0);
      ioctl_rd = 1'b0;
      tick();
      ioctl_upload = 1'b1;
      repeat (2) tick();
      r0 = req_rises;
      host_read(25'h5, mem_word(12'h2) >> 8, "refetch", wc);
      check("refetch_wait_clocks", 32'(wc), 32'd4);
      check("refetch_req_count", 32'(req_rises - r0), 32'd1);

      // reset in the middle of a fetch
      hold_cycles = 50;
      ioctl_addr = 25'h8;
      ioctl_rd   = 1'b1;
      tick();
      check("mid_req_hi", 32'(mem_req), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_req", 32'(mem_req), 32'h0);
      check("mid_rst_wait", 32'(ioctl_wait), 32'h0);
      check("mid_rst_din", 32'(ioctl_din), 32'h0);
      check("mid_rst_bytes", 32'(bytes_read), 32'h0);
      check("mid_rst_active", 32'(upload_active), 32'h0);
      tick();
      hold_cycles = 0;
      ioctl_rd = 1'b0;
      reset_n = 1'b1;
      repeat (2) tick();
      check("post_rst_bytes", 32'(bytes_read), 32'h0);
      check("post_rst_state", 32'(fsm_state), 32'h0);
      check("post_rst_active", 32'(upload_active), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
